// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: stall/flush sequencer for the 5-stage rv32i pipeline.
// Handles load-use bubbles, instruction/data memory wait freezes, and
// mispredict squashes. A redirect that arrives while a fetch is in flight is
// held in redirect_pc_o until the stale fetch drains.
module hazard_stall_ctrl #(
    parameter int width     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [4:0]           ID_rs1_i,
    input  logic [4:0]           ID_rs2_i,
    input  logic                 ID_use_rs1_i,
    input  logic                 ID_use_rs2_i,
    input  logic [4:0]           ID_EX_rd_i,
    input  logic                 ID_EX_mem_read_i,
    input  logic                 EX_mispredict_i,
    input  logic [width-1:0]     EX_target_i,
    input  logic                 imem_read_i,
    input  logic                 imem_resp_i,
    input  logic                 dmem_req_i,
    input  logic                 dmem_resp_i,
    output logic                 pc_load_o,
    output logic                 pc_redirect_o,
    output logic [width-1:0]     redirect_pc_o,
    output logic                 IF_ID_load_o,
    output logic                 ID_EX_load_o,
    output logic                 EX_MEM_load_o,
    output logic                 MEM_WB_load_o,
    output logic                 IF_ID_flush_o,
    output logic                 ID_EX_flush_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o
);

    typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

    state_t state, state_next;

    logic dstall, istall, lu;
    logic take_flush, take_redirect;

    // Ungated control values; forced to zero below while reset is asserted.
    logic pc_load, pc_redirect, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic if_id_flush, id_ex_flush;

    assign dstall = dmem_req_i & ~dmem_resp_i;
    assign istall = imem_read_i & ~imem_resp_i;
    assign lu     = ID_EX_mem_read_i & (ID_EX_rd_i != 5'd0) &
                    (((ID_EX_rd_i == ID_rs1_i) & ID_use_rs1_i) |
                     ((ID_EX_rd_i == ID_rs2_i) & ID_use_rs2_i));

    // A mispredict is only acted on in RUN when the data side is not frozen.
    assign take_flush    = (state == RUN) & ~dstall & EX_mispredict_i;
    assign take_redirect = take_flush & istall;

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= RUN;
        else          state <= state_next;
    end

    // Next-state: park in DRAIN until the in-flight fetch returns.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (take_redirect) state_next = DRAIN;
            DRAIN:   if (imem_resp_i)   state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Output decode by state and hazard priority.
    always_comb begin
        pc_load     = 1'b1;
        pc_redirect = 1'b0;
        if_id_load  = 1'b1;
        id_ex_load  = 1'b1;
        ex_mem_load = 1'b1;
        mem_wb_load = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        case (state)
            RUN: begin
                if (dstall) begin
                    // Whole pipe frozen; a pending mispredict stays in EX.
                    pc_load     = 1'b0;
                    if_id_load  = 1'b0;
                    id_ex_load  = 1'b0;
                    ex_mem_load = 1'b0;
                    mem_wb_load = 1'b0;
                end else if (EX_mispredict_i) begin
                    // Without a fetch in flight the branch path supplies the PC.
                    pc_load     = ~istall;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (lu || istall) begin
                    pc_load     = 1'b0;
                    if_id_load  = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
            DRAIN: begin
                pc_load     = 1'b0;
                if_id_load  = 1'b0;
                id_ex_flush = 1'b1;
                if (dstall) begin
                    ex_mem_load = 1'b0;
                    mem_wb_load = 1'b0;
                end
                if (imem_resp_i) begin
                    // Stale word is discarded and the held target is loaded.
                    if_id_flush = 1'b1;
                    pc_load     = 1'b1;
                    pc_redirect = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Reset holds every enable and flush low.
    assign pc_load_o     = rst_n_i & pc_load;
    assign pc_redirect_o = rst_n_i & pc_redirect;
    assign IF_ID_load_o  = rst_n_i & if_id_load;
    assign ID_EX_load_o  = rst_n_i & id_ex_load;
    assign EX_MEM_load_o = rst_n_i & ex_mem_load;
    assign MEM_WB_load_o = rst_n_i & mem_wb_load;
    assign IF_ID_flush_o = rst_n_i & if_id_flush;
    assign ID_EX_flush_o = rst_n_i & id_ex_flush;

    // Capture the redirect target when the redirect has to wait for a fetch.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)          redirect_pc_o <= '0;
        else if (take_redirect) redirect_pc_o <= EX_target_i;
    end

    // Saturating count of cycles where the PC did not advance.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            stall_cnt_o <= '0;
        else if (!pc_load && (stall_cnt_o != {CNT_WIDTH{1'b1}}))
            stall_cnt_o <= stall_cnt_o + CNT_WIDTH'(1);
    end

    // Saturating count of mispredict flush events.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            flush_cnt_o <= '0;
        else if (take_flush && (flush_cnt_o != {CNT_WIDTH{1'b1}}))
            flush_cnt_o <= flush_cnt_o + CNT_WIDTH'(1);
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed testbench for hazard_stall_ctrl: a default instance plus a
// 4-bit-counter instance sharing the same stimulus for saturation checks.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1, rs2, ex_rd;
    logic        use_rs1, use_rs2, mem_read, mispredict;
    logic [31:0] target;
    logic        imem_read, imem_resp, dmem_req, dmem_resp;

    logic        pc_load, pc_redirect, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic        if_id_flush, id_ex_flush;
    logic [31:0] redirect_pc;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc_load, s_pc_redirect, s_if_id_load, s_id_ex_load, s_ex_mem_load, s_mem_wb_load;
    logic        s_if_id_flush, s_id_ex_flush;
    logic [31:0] s_redirect_pc;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    logic [4:0]  loads;
    logic [2:0]  ctl;

    int passed = 0;
    int total  = 0;

    assign loads = {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load};
    assign ctl   = {if_id_flush, id_ex_flush, pc_redirect};

    always #5 clk = ~clk;

    hazard_stall_ctrl dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .ID_rs1_i(rs1), .ID_rs2_i(rs2), .ID_use_rs1_i(use_rs1), .ID_use_rs2_i(use_rs2),
        .ID_EX_rd_i(ex_rd), .ID_EX_mem_read_i(mem_read),
        .EX_mispredict_i(mispredict), .EX_target_i(target),
        .imem_read_i(imem_read), .imem_resp_i(imem_resp),
        .dmem_req_i(dmem_req), .dmem_resp_i(dmem_resp),
        .pc_load_o(pc_load), .pc_redirect_o(pc_redirect), .redirect_pc_o(redirect_pc),
        .IF_ID_load_o(if_id_load), .ID_EX_load_o(id_ex_load),
        .EX_MEM_load_o(ex_mem_load), .MEM_WB_load_o(mem_wb_load),
        .IF_ID_flush_o(if_id_flush), .ID_EX_flush_o(id_ex_flush),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    hazard_stall_ctrl #(.width(32), .CNT_WIDTH(4)) dut_small (
        .clk_i(clk), .rst_n_i(rst_n),
        .ID_rs1_i(rs1), .ID_rs2_i(rs2), .ID_use_rs1_i(use_rs1), .ID_use_rs2_i(use_rs2),
        .ID_EX_rd_i(ex_rd), .ID_EX_mem_read_i(mem_read),
        .EX_mispredict_i(mispredict), .EX_target_i(target),
        .imem_read_i(imem_read), .imem_resp_i(imem_resp),
        .dmem_req_i(dmem_req), .dmem_resp_i(dmem_resp),
        .pc_load_o(s_pc_load), .pc_redirect_o(s_pc_redirect), .redirect_pc_o(s_redirect_pc),
        .IF_ID_load_o(s_if_id_load), .ID_EX_load_o(s_id_ex_load),
        .EX_MEM_load_o(s_ex_mem_load), .MEM_WB_load_o(s_mem_wb_load),
        .IF_ID_flush_o(s_if_id_flush), .ID_EX_flush_o(s_id_ex_flush),
        .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rs1 = 5'd0; rs2 = 5'd0; ex_rd = 5'd0;
        use_rs1 = 1'b0; use_rs2 = 1'b0; mem_read = 1'b0; mispredict = 1'b0;
        target = 32'h0;
        imem_read = 1'b0; imem_resp = 1'b0; dmem_req = 1'b0; dmem_resp = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #2;
        chk("reset_loads", 32'(loads), 32'h00);
        chk("reset_ctl", 32'(ctl), 32'h0);
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("reset_redirect_pc", redirect_pc, 32'h0);
        #6 rst_n = 1'b1;
        tick();

        // Idle pipe
        #1;
        chk("idle_loads", 32'(loads), 32'h1F);
        chk("idle_ctl", 32'(ctl), 32'h0);
        tick();

        // Load-use on rs1
        mem_read = 1'b1; ex_rd = 5'd5; rs1 = 5'd5; use_rs1 = 1'b1;
        #1;
        $display("step lu_rs1 loads=%b ctl=%b", loads, ctl);
        chk("lu_rs1_loads", 32'(loads), 32'h07);
        chk("lu_rs1_ctl", 32'(ctl), 32'h2);
        tick();
        mem_read = 1'b0;
        #1;
        chk("lu_after_loads", 32'(loads), 32'h1F);
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        tick();

        // rd = x0 never stalls
        mem_read = 1'b1; ex_rd = 5'd0; rs1 = 5'd0; use_rs1 = 1'b1;
        #1;
        chk("rd_x0_loads", 32'(loads), 32'h1F);
        tick();

        // Load-use on rs2, then same registers with use_rs2 cleared
        ex_rd = 5'd7; rs1 = 5'd3; rs2 = 5'd7; use_rs2 = 1'b1;
        #1;
        chk("lu_rs2_loads", 32'(loads), 32'h07);
        tick();
        mem_read = 1'b0;
        #1;
        tick();
        mem_read = 1'b1; use_rs2 = 1'b0;
        #1;
        chk("rs2_unused_loads", 32'(loads), 32'h1F);
        tick();
        idle_inputs();

        // Data miss for 3 cycles with a pending mispredict
        dmem_req = 1'b1; mispredict = 1'b1; target = 32'h40;
        for (int i = 0; i < 3; i++) begin
            #1;
            $display("step dmiss%0d loads=%b ctl=%b", i, loads, ctl);
            chk("dmiss_loads", 32'(loads), 32'h00);
            chk("dmiss_ctl", 32'(ctl), 32'h0);
            tick();
        end
        dmem_resp = 1'b1;
        #1;
        chk("dmiss_release_loads", 32'(loads), 32'h1F);
        chk("dmiss_release_ctl", 32'(ctl), 32'h6);
        tick();
        idle_inputs();
        #1;
        chk("flush_cnt_1", 32'(flush_cnt), 32'd1);
        chk("stall_cnt_5", 32'(stall_cnt), 32'd5);

        // Redirect while a fetch is in flight
        imem_read = 1'b1; mispredict = 1'b1; target = 32'h60;
        #1;
        chk("redir_loads", 32'(loads), 32'h0F);
        chk("redir_ctl", 32'(ctl), 32'h6);
        tick();
        chk("redir_pc", redirect_pc, 32'h60);
        chk("flush_cnt_2", 32'(flush_cnt), 32'd2);
        // DRAIN: a stray mispredict must be ignored
        target = 32'h99;
        #1;
        chk("drain_loads", 32'(loads), 32'h07);
        chk("drain_ctl", 32'(ctl), 32'h2);
        tick();
        chk("drain_pc_held", redirect_pc, 32'h60);
        chk("drain_flush_cnt", 32'(flush_cnt), 32'd2);
        mispredict = 1'b0; dmem_req = 1'b1;
        #1;
        chk("drain_dstall_loads", 32'(loads), 32'h04);
        chk("drain_dstall_ctl", 32'(ctl), 32'h2);
        tick();
        dmem_req = 1'b0; imem_resp = 1'b1;
        #1;
        $display("step drain_resp loads=%b ctl=%b", loads, ctl);
        chk("drain_resp_loads", 32'(loads), 32'h17);
        chk("drain_resp_ctl", 32'(ctl), 32'h7);
        tick();
        idle_inputs();
        #1;
        chk("back_run_loads", 32'(loads), 32'h1F);
        chk("back_run_ctl", 32'(ctl), 32'h0);
        tick();

        // Plain fetch stall
        imem_read = 1'b1;
        #1;
        chk("istall_loads", 32'(loads), 32'h07);
        chk("istall_ctl", 32'(ctl), 32'h2);
        tick();
        chk("stall_cnt_9", 32'(stall_cnt), 32'd9);
        chk("small_stall_cnt_9", 32'(s_stall_cnt), 32'd9);

        // Saturation of the 4-bit counter
        for (int i = 0; i < 20; i++) tick();
        chk("stall_cnt_29", 32'(stall_cnt), 32'd29);
        chk("small_stall_sat", 32'(s_stall_cnt), 32'd15);
        chk("small_flush_cnt", 32'(s_flush_cnt), 32'd2);

        // Async reset in the middle of DRAIN
        mispredict = 1'b1; target = 32'h44;
        tick();
        mispredict = 1'b0;
        chk("drain2_pc", redirect_pc, 32'h44);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_loads", 32'(loads), 32'h00);
        chk("async_rst_ctl", 32'(ctl), 32'h0);
        chk("async_rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("async_rst_flush_cnt", 32'(flush_cnt), 32'd0);
        chk("async_rst_pc", redirect_pc, 32'h0);
        imem_resp = 1'b1;
        #1 rst_n = 1'b1;
        #1;
        // In RUN a returning fetch is not a redirect
        chk("post_rst_loads", 32'(loads), 32'h1F);
        chk("post_rst_ctl", 32'(ctl), 32'h0);
        tick();
        chk("post_rst_stall_cnt", 32'(stall_cnt), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
